// File: rtl/alu_defs_pkg.sv
// Shared ALU op codes, MIPS opcode/funct constants and the issue payload type.
package alu_defs_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SLL  = 4'b0011,
        ALU_SRL  = 4'b0100,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_ADDU = 4'b1000,
        ALU_SUBU = 4'b1001,
        ALU_XOR  = 4'b1010,
        ALU_SLTU = 4'b1011,
        ALU_NOR  = 4'b1100,
        ALU_SRA  = 4'b1101,
        ALU_LUI  = 4'b1110
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    typedef struct packed {
        alu_op_e     ctrl;
        logic [31:0] bus_a;
        logic [31:0] bus_b;
        logic [4:0]  write_reg;
        logic        reg_write;
        logic        illegal;
    } issue_payload_t;

    localparam issue_payload_t PAYLOAD_ILLEGAL = '{
        ctrl: ALU_AND, bus_a: '0, bus_b: '0, write_reg: '0, reg_write: 1'b0, illegal: 1'b1
    };

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational MIPS decode to ALU op, operands and destination.
// ALU_ISSUE_VARSHIFT_EN enables SLLV/SRLV/SRAV decode.
module alu_issue_decode
    import alu_defs_pkg::*;
(
    input  logic [31:0]    Instr,
    input  logic [31:0]    RsData,
    input  logic [31:0]    RtData,
    output issue_payload_t Next
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [31:0] sext;
    logic [31:0] zext;
    logic        unused_rs;

    assign opcode    = Instr[31:26];
    assign rt        = Instr[20:16];
    assign rd        = Instr[15:11];
    assign shamt     = Instr[10:6];
    assign funct     = Instr[5:0];
    assign imm       = Instr[15:0];
    assign sext      = {{16{imm[15]}}, imm};
    assign zext      = {16'b0, imm};
    // Operand A comes from RsData; the rs field itself is the register-file's concern.
    assign unused_rs = ^Instr[25:21];

    always_comb begin
        Next = '0;
        case (opcode)
            OP_RTYPE: begin
                Next.bus_a     = RsData;
                Next.bus_b     = RtData;
                Next.write_reg = rd;
                Next.reg_write = 1'b1;
                case (funct)
                    F_ADD:  Next.ctrl = ALU_ADD;
                    F_ADDU: Next.ctrl = ALU_ADDU;
                    F_SUB:  Next.ctrl = ALU_SUB;
                    F_SUBU: Next.ctrl = ALU_SUBU;
                    F_AND:  Next.ctrl = ALU_AND;
                    F_OR:   Next.ctrl = ALU_OR;
                    F_XOR:  Next.ctrl = ALU_XOR;
                    F_NOR:  Next.ctrl = ALU_NOR;
                    F_SLT:  Next.ctrl = ALU_SLT;
                    F_SLTU: Next.ctrl = ALU_SLTU;
                    // ALU shifts BusB by BusA, so the shift amount rides on A.
                    F_SLL: begin Next.ctrl = ALU_SLL; Next.bus_a = {27'b0, shamt}; end
                    F_SRL: begin Next.ctrl = ALU_SRL; Next.bus_a = {27'b0, shamt}; end
                    F_SRA: begin Next.ctrl = ALU_SRA; Next.bus_a = {27'b0, shamt}; end
`ifdef ALU_ISSUE_VARSHIFT_EN
                    F_SLLV: begin Next.ctrl = ALU_SLL; Next.bus_a = {27'b0, RsData[4:0]}; end
                    F_SRLV: begin Next.ctrl = ALU_SRL; Next.bus_a = {27'b0, RsData[4:0]}; end
                    F_SRAV: begin Next.ctrl = ALU_SRA; Next.bus_a = {27'b0, RsData[4:0]}; end
`endif
                    default: Next = PAYLOAD_ILLEGAL;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW, OP_SW: begin
                Next.bus_a     = RsData;
                Next.bus_b     = sext;
                Next.write_reg = rt;
                Next.reg_write = (opcode != OP_SW);
                case (opcode)
                    OP_ADDIU: Next.ctrl = ALU_ADDU;
                    OP_SLTI:  Next.ctrl = ALU_SLT;
                    OP_SLTIU: Next.ctrl = ALU_SLTU;
                    default:  Next.ctrl = ALU_ADD;
                endcase
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                Next.bus_a     = RsData;
                Next.bus_b     = zext;
                Next.write_reg = rt;
                Next.reg_write = 1'b1;
                case (opcode)
                    OP_ANDI: Next.ctrl = ALU_AND;
                    OP_ORI:  Next.ctrl = ALU_OR;
                    OP_XORI: Next.ctrl = ALU_XOR;
                    default: Next.ctrl = ALU_LUI;
                endcase
            end
            OP_BEQ: begin
                Next.ctrl      = ALU_SUB;
                Next.bus_a     = RsData;
                Next.bus_b     = RtData;
                Next.write_reg = rt;
            end
            default: Next = PAYLOAD_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decoded ALU payload with valid/ready, flush and issue counter.
// Build option ALU_ISSUE_VARSHIFT_EN is handled in alu_issue_decode.
module alu_issue_stage
    import alu_defs_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [31:0]      Instr,
    input  logic [31:0]      RsData,
    input  logic [31:0]      RtData,
    input  logic             Flush,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [3:0]       ALUCtrl,
    output logic [31:0]      BusA,
    output logic [31:0]      BusB,
    output logic [4:0]       WriteReg,
    output logic             RegWrite,
    output logic             IllegalInstr,
    output logic [CNT_W-1:0] IssueCount
);

    issue_payload_t nxt;
    issue_payload_t held;
    logic           accept;

    alu_issue_decode u_decode (
        .Instr  (Instr),
        .RsData (RsData),
        .RtData (RtData),
        .Next   (nxt)
    );

    assign InReady = !OutValid || OutReady;
    assign accept  = InValid && InReady && !Flush;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            OutValid   <= 1'b0;
            held       <= '0;
            IssueCount <= '0;
        end else if (accept) begin
            OutValid   <= 1'b1;
            held       <= nxt;
            IssueCount <= IssueCount + 1'b1;
        end else if (Flush || OutReady) begin
            // Payload deliberately holds; only the valid bit drops.
            OutValid <= 1'b0;
        end
    end

    assign ALUCtrl      = held.ctrl;
    assign BusA         = held.bus_a;
    assign BusB         = held.bus_b;
    assign WriteReg     = held.write_reg;
    assign RegWrite     = held.reg_write;
    assign IllegalInstr = held.illegal;

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Registered decode/issue stage that drives the single-cycle ALU's `ALUCtrl`, `BusA` and `BusB` inputs from a raw MIPS instruction and register-file read data. It decodes opcode/funct into the 4-bit ALU operation code and selects and extends operands. It holds the result in a valid/ready output register (the ID/EX boundary) with stall and flush support. It sits between the register file and the ALU in the Lab 6 pipelined datapath.

## Interface
Parameters:
- `CNT_W`, 16, width of the issued-instruction counter.

Ports:
- `Clk`  in  1  the only clock; all state updates on its rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `InValid`  in  1  `Instr`/`RsData`/`RtData` are valid this cycle.
- `InReady`  out  1  stage can accept; defined as `!OutValid || OutReady`.
- `Instr`  in  32  MIPS instruction word.
- `RsData`  in  32  register-file read of `rs`.
- `RtData`  in  32  register-file read of `rt`.
- `Flush`  in  1  discard held and incoming instruction.
- `OutValid`  out  1  output register holds an issued instruction.
- `OutReady`  in  1  downstream consumes this cycle.
- `ALUCtrl`  out  4  ALU operation code.
- `BusA`, `BusB`  out  32 each  ALU operands.
- `WriteReg`  out  5  destination register: `rd` for R-type, `rt` for I-type.
- `RegWrite`  out  1  instruction writes a register.
- `IllegalInstr`  out  1  opcode/funct not decoded.
- `IssueCount`  out  `CNT_W`  count of accepted instructions; wraps.

## Operation
- Op codes:
  - AND=0000, OR=0001, ADD=0010, SLL=0011, SRL=0100, SUB=0110, SLT=0111.
  - ADDU=1000, SUBU=1001, XOR=1010, SLTU=1011, NOR=1100, SRA=1101, LUI=1110.
- R-type (opcode 0x00), by funct:
  - Arithmetic/logic: 0x20 ADD, 0x21 ADDU, 0x22 SUB, 0x23 SUBU, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x2B SLTU.
  - Operands: `BusA=RsData`, `BusB=RtData`, `WriteReg=rd`, `RegWrite=1`.
- Constant shifts: 0x00 SLL, 0x02 SRL, 0x03 SRA.
  - The ALU shifts `BusB` by `BusA`, so `BusA={27'b0,shamt}` and `BusB=RtData`.
- I-type:
  - Sign-extended immediate on `BusB`: 0x08 ADD, 0x09 ADDU, 0x0A SLT, 0x0B SLTU.
  - Zero-extended immediate on `BusB`: 0x0C AND, 0x0D OR, 0x0E XOR.
  - 0x0F LUI: `BusB={16'b0,imm}`; the ALU does the shift.
  - Common fields: `BusA=RsData`, `WriteReg=rt`, `RegWrite=1`.
- Memory and branch:
  - lw 0x23: ADD, sign-extended immediate, `RegWrite=1`.
  - sw 0x2B: ADD, sign-extended immediate, `RegWrite=0`.
  - beq 0x04: SUB, `BusB=RtData`, `RegWrite=0`.
- Any other opcode/funct is illegal:
  - `IllegalInstr=1`, `ALUCtrl=AND`, `RegWrite=0`, `BusA=BusB=0`.
  - Still issued with `OutValid=1`.
- Accept occurs when `InValid && InReady && !Flush`:
  - all outputs load;
  - `OutValid<=1`;
  - `IssueCount` increments and wraps modulo 2^`CNT_W`.
- Consume without accept (`OutReady && !accept`): `OutValid<=0`; payload outputs hold their last values.
- Stall (`OutValid && !OutReady`): all outputs held bit-exact; `InReady=0`.
- `Flush` has priority over accept:
  - `OutValid<=0`; no increment.
  - Payload outputs hold.
  - `InReady` is unaffected by `Flush`.
- `Rst` has priority over everything.

## Timing
- Latency: 1 cycle from accept to `OutValid`.
- Throughput: 1 instruction per cycle while `OutReady=1`.
- Combinational paths:
  - `InReady` depends only on `OutValid` and `OutReady`.
  - No path from `Instr` to any output.
- Reset values:
  - `OutValid`, `IllegalInstr`, `RegWrite` = 0.
  - `ALUCtrl`, `BusA`, `BusB`, `WriteReg`, `IssueCount` = 0.
  - `InReady` = 1 (combinational from `OutValid=0`).
- Reset mid-stall drops the held instruction; the next cycle accepts normally.

## Configuration
- Macro `ALU_ISSUE_VARSHIFT_EN`.
- Defined: R-type funct 0x04 SLLV, 0x06 SRLV, 0x07 SRAV decode to SLL/SRL/SRA.
  - `BusA={27'b0,RsData[4:0]}` (masked, since the ALU shifts by all 32 bits), `BusB=RtData`.
- Undefined: those functs are illegal.

## Structure
- Shared package `alu_defs_pkg`:
  - the 4-bit ALU op-code constants (shared with the ALU);
  - opcode and funct constants.
- Sub-module `alu_issue_decode`: purely combinational decoder mapping `Instr`, `RsData`, `RtData` to the next payload and the illegal flag.
- The top holds the output register, handshake and counter.

## Test plan
- add: `Instr=0x00221820`, `RsData=5`, `RtData=7`, valid for one cycle, `OutReady=1`.
  - Next cycle: `OutValid=1`, `ALUCtrl=0010`, `BusA=5`, `BusB=7`, `WriteReg=3`, `RegWrite=1`, `IssueCount=1`.
- sll: `Instr=0x00011100`, `RtData=0x1`.
  - Expect `ALUCtrl=0011`, `BusA=4`, `BusB=1`, `WriteReg=2`.
- Immediate extension:
  - `0x2005FFFF` → `ALUCtrl=0010`, `BusB=0xFFFFFFFF`, `WriteReg=5`.
  - `0x3405FFFF` → `ALUCtrl=0001`, `BusB=0x0000FFFF`.
  - `0x3C051234` → `ALUCtrl=1110`, `BusB=0x00001234`.
- Backpressure:
  - After issue, hold `OutReady=0` for 3 cycles while `InValid=1` → `InReady=0` and outputs stable.
  - Set `OutReady=1` → next instruction appears the following cycle.
- Flush:
  - Assert `Flush` on a cycle where `InValid=1` with a held instruction → `OutValid=0` next cycle, `IssueCount` unchanged.
  - Assert `Rst` during a stall → all outputs return to their reset values.
- Illegal and variable shift: opcode 0x3F → `IllegalInstr=1`, `RegWrite=0`.
  - Funct 0x04 with `RsData=0x23` → with the macro, `ALUCtrl=0011`, `BusA=3`; without it, `IllegalInstr=1`.
